// File: rtl/walnut_pkg.sv
// Shared definitions for the wall-nut sprite: stage encoding, native-grid band table,
// feature rectangles and the geometry/stage helper functions.
package walnut_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_CRACKED  = 2'd2,
        ST_CRUMBLED = 2'd3
    } stage_e;

    // Rectangle on the native 76x120 grid, inclusive bounds.
    typedef struct packed {
        int unsigned r0;
        int unsigned r1;
        int unsigned c0;
        int unsigned c1;
    } rect_t;

    localparam int unsigned NBANDS = 39;
    localparam int unsigned NATIVE_W = 76;

    // Left inset of each 6-row body band; the band is mirrored about the vertical centre.
    localparam int unsigned BAND_L [NBANDS] = '{
        27, 23, 19, 17, 15, 13, 11, 9, 8, 7, 6, 5, 4, 3, 2, 1,
        0, 0, 0, 0, 0, 0, 0,
        1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 13, 15, 17, 19, 23, 27
    };

    localparam rect_t WHITE_A = '{44, 70, 30, 47};
    localparam rect_t WHITE_B = '{47, 65, 55, 69};
    localparam rect_t PUPIL_A = '{49, 65, 35, 45};
    localparam rect_t PUPIL_B = '{51, 63, 59, 67};
    localparam rect_t MOUTH_A = '{74, 79, 39, 44};
    localparam rect_t MOUTH_B = '{76, 81, 42, 59};
    localparam rect_t MOUTH_C = '{74, 79, 57, 62};
    localparam rect_t CRACK_A = '{10, 40, 50, 53};
    localparam rect_t CRACK_B = '{80, 112, 20, 23};

    function automatic rect_t band_rect(input int unsigned k);
        rect_t b;
        b.r0 = 3 * k;
        b.r1 = 3 * k + 5;
        b.c0 = BAND_L[k];
        b.c1 = (NATIVE_W - 1) - BAND_L[k];
        return b;
    endfunction

    // Native bounds are scaled down (truncating) before comparison with the raw offsets.
    function automatic logic in_rect(input logic [10:0] dh, input logic [10:0] dv,
                                     input rect_t r, input int unsigned ws);
        return (dv >= 11'(r.r0 / ws)) && (dv <= 11'(r.r1 / ws)) &&
               (dh >= 11'(r.c0 / ws)) && (dh <= 11'(r.c1 / ws));
    endfunction

    function automatic stage_e stage_of(input logic [7:0] h, input int unsigned crack_th,
                                        input int unsigned crumble_th);
        if (32'(h) > crack_th)   return ST_FULL;
        if (32'(h) > crumble_th) return ST_CRACKED;
        if (h != 8'd0)           return ST_CRUMBLED;
        return ST_EMPTY;
    endfunction

endpackage

// File: rtl/walnut_shape.sv
// Combinational wall-nut sprite decode: offsets inside the box plus blink/stage to raw pixel flags.
module walnut_shape
    import walnut_pkg::*;
#(
    parameter int unsigned WSCALE = 2
) (
    input  logic [10:0] i_dh,
    input  logic [10:0] i_dv,
    input  logic        i_blink,
    input  stage_e      i_stage,
    output logic        o_body,
    output logic        o_white,
    output logic        o_black,
    output logic        o_crack
);

    logic w_mouth;
    logic w_pupil;
    logic w_eyewhite;

    always_comb begin
        o_body = 1'b0;
        for (int unsigned k = 0; k < NBANDS; k++) begin
            if (in_rect(i_dh, i_dv, band_rect(k), WSCALE)) o_body = 1'b1;
        end
    end

    always_comb begin
        w_eyewhite = in_rect(i_dh, i_dv, WHITE_A, WSCALE) | in_rect(i_dh, i_dv, WHITE_B, WSCALE);
        w_pupil    = in_rect(i_dh, i_dv, PUPIL_A, WSCALE) | in_rect(i_dh, i_dv, PUPIL_B, WSCALE);
        w_mouth    = in_rect(i_dh, i_dv, MOUTH_A, WSCALE) | in_rect(i_dh, i_dv, MOUTH_B, WSCALE) |
                     in_rect(i_dh, i_dv, MOUTH_C, WSCALE);
        o_white    = ~i_blink & w_eyewhite;
        // The mouth shares the black flag but stays visible through a blink.
        o_black    = (~i_blink & w_pupil) | w_mouth;
        o_crack    = (((i_stage == ST_CRACKED) || (i_stage == ST_CRUMBLED)) &
                      in_rect(i_dh, i_dv, CRACK_A, WSCALE)) |
                     ((i_stage == ST_CRUMBLED) & in_rect(i_dh, i_dv, CRACK_B, WSCALE));
    end

endmodule

// File: rtl/walnut_unit.sv
// Stateful wall-nut: health/stage FSM, frame-timed blink and bite flash, and the registered
// pixel flags handed to the colour mux one cycle after the raster position.
module walnut_unit
    import walnut_pkg::*;
#(
    parameter int unsigned WSCALE       = 2,
    parameter int unsigned MAX_HEALTH   = 12,
    parameter int unsigned CRACK_TH     = 8,
    parameter int unsigned CRUMBLE_TH   = 4,
    parameter int unsigned BLINK_PERIOD = 120,
    parameter int unsigned BLINK_LEN    = 6,
    parameter int unsigned FLASH_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       plant,
    input  logic [9:0] plant_h,
    input  logic [9:0] plant_v,
    input  logic       bite,
    output logic       alive,
    output logic [7:0] health,
    output logic [1:0] stage,
    output logic       dead,
    output logic       walnut,
    output logic       walnutWhite,
    output logic       walnutBlack,
    output logic       walnutCrack,
    output logic       walnutFlash
);

    localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);

    stage_e        r_stage;
    logic [7:0]    r_health;
    logic [9:0]    r_pos_h;
    logic [9:0]    r_pos_v;
    logic          r_dead;
    logic          r_at_origin;
    logic [BW-1:0] r_blink_cnt;
    logic [FW-1:0] r_flash;
    logic          r_walnut;
    logic          r_white;
    logic          r_black;
    logic          r_crack;
    logic          r_flashpix;

    logic          w_alive;
    logic          w_at_origin;
    logic          w_tick;
    logic          w_bite_ok;
    logic [7:0]    w_health_nx;
    logic          w_inside;
    logic          w_gate;
    logic          w_blink;
    logic [10:0]   w_dh;
    logic [10:0]   w_dv;
    logic          w_body;
    logic          w_white;
    logic          w_black;
    logic          w_crack;

    assign w_alive     = (r_stage != ST_EMPTY);
    assign w_at_origin = (hCount == 10'd0) && (vCount == 10'd0);
    assign w_tick      = w_at_origin & ~r_at_origin;
    assign w_bite_ok   = bite & w_alive & ~plant;
    assign w_health_nx = r_health - 8'd1;
    assign w_blink     = (r_blink_cnt >= BW'(BLINK_PERIOD - BLINK_LEN));

    // 11-bit offsets so a nut placed near column 1023 never wraps back onto the left edge.
    assign w_dh     = {1'b0, hCount} - {1'b0, r_pos_h};
    assign w_dv     = {1'b0, vCount} - {1'b0, r_pos_v};
    assign w_inside = (hCount >= r_pos_h) && (vCount >= r_pos_v);
    assign w_gate   = w_alive & w_inside;

    walnut_shape #(
        .WSCALE(WSCALE)
    ) u_shape (
        .i_dh   (w_dh),
        .i_dv   (w_dv),
        .i_blink(w_blink),
        .i_stage(r_stage),
        .o_body (w_body),
        .o_white(w_white),
        .o_black(w_black),
        .o_crack(w_crack)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage     <= ST_EMPTY;
            r_health    <= '0;
            r_pos_h     <= '0;
            r_pos_v     <= '0;
            r_dead      <= 1'b0;
            r_at_origin <= 1'b0;
            r_blink_cnt <= '0;
            r_flash     <= '0;
            r_walnut    <= 1'b0;
            r_white     <= 1'b0;
            r_black     <= 1'b0;
            r_crack     <= 1'b0;
            r_flashpix  <= 1'b0;
        end else begin
            r_at_origin <= w_at_origin;
            r_dead      <= 1'b0;
            if (plant) begin
                r_pos_h     <= plant_h;
                r_pos_v     <= plant_v;
                r_health    <= 8'(MAX_HEALTH);
                r_stage     <= stage_of(8'(MAX_HEALTH), CRACK_TH, CRUMBLE_TH);
                r_blink_cnt <= '0;
                r_flash     <= '0;
            end else begin
                if (w_bite_ok) begin
                    r_health <= w_health_nx;
                    r_stage  <= stage_of(w_health_nx, CRACK_TH, CRUMBLE_TH);
                    r_flash  <= FW'(FLASH_FRAMES);
                    r_dead   <= (w_health_nx == 8'd0);
                end else if (w_tick && (r_flash != '0)) begin
                    r_flash <= r_flash - 1'b1;
                end
                if (w_tick && w_alive) begin
                    r_blink_cnt <= (r_blink_cnt == BW'(BLINK_PERIOD - 1)) ? '0 : r_blink_cnt + 1'b1;
                end
            end
            r_walnut   <= w_gate & w_body;
            r_white    <= w_gate & w_white;
            r_black    <= w_gate & w_black;
            r_crack    <= w_gate & w_crack;
            r_flashpix <= w_gate & w_body & (r_flash != '0);
        end
    end

    assign alive       = w_alive;
    assign health      = r_health;
    assign stage       = r_stage;
    assign dead        = r_dead;
    assign walnut      = r_walnut;
    assign walnutWhite = r_white;
    assign walnutBlack = r_black;
    assign walnutCrack = r_crack;
    assign walnutFlash = r_flashpix;

endmodule

// File: tb/tb_walnut_unit.sv
// Scoreboard bench for walnut_unit: two instances (WSCALE 2 and 1) share stimulus and are
// compared every cycle against a frame/health-level reference model.
module tb_walnut_unit;

    localparam int MAXH = 12;
    localparam int CRK  = 8;
    localparam int CRM  = 4;
    localparam int BP   = 120;
    localparam int BL   = 6;
    localparam int FF   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       plant = 1'b0;
    logic       bite = 1'b0;
    logic [9:0] hCount = '0;
    logic [9:0] vCount = '0;
    logic [9:0] plant_h = '0;
    logic [9:0] plant_v = '0;

    always #5 clk = ~clk;

    logic       al2, dd2, wn2, wh2, bk2, ck2, fl2;
    logic [7:0] hp2;
    logic [1:0] st2;
    logic       al1, dd1, wn1, wh1, bk1, ck1, fl1;
    logic [7:0] hp1;
    logic [1:0] st1;

    walnut_unit #(.WSCALE(2)) u_ws2 (
        .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
        .plant(plant), .plant_h(plant_h), .plant_v(plant_v), .bite(bite),
        .alive(al2), .health(hp2), .stage(st2), .dead(dd2),
        .walnut(wn2), .walnutWhite(wh2), .walnutBlack(bk2), .walnutCrack(ck2), .walnutFlash(fl2)
    );

    walnut_unit #(.WSCALE(1)) u_ws1 (
        .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
        .plant(plant), .plant_h(plant_h), .plant_v(plant_v), .bite(bite),
        .alive(al1), .health(hp1), .stage(st1), .dead(dd1),
        .walnut(wn1), .walnutWhite(wh1), .walnutBlack(bk1), .walnutCrack(ck1), .walnutFlash(fl1)
    );

    logic [16:0] act2, act1;
    assign act2 = {al2, hp2, st2, dd2, wn2, wh2, bk2, ck2, fl2};
    assign act1 = {al1, hp1, st1, dd1, wn1, wh1, bk1, ck1, fl1};

    typedef struct {
        logic [16:0] e2;
        logic [16:0] e1;
    } exp_t;
    exp_t q[$];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state, tracked in frames and bites rather than counters.
    bit m_alive, m_dead, m_prev_org;
    int m_health, m_ph, m_pv, m_frames, m_flash;

    int L_TAB [39] = '{27, 23, 19, 17, 15, 13, 11, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0,
                       1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 13, 15, 17, 19, 23, 27};

    function automatic bit inr(int dh, int dv, int r0, int r1, int c0, int c1, int w);
        return dv >= r0 / w && dv <= r1 / w && dh >= c0 / w && dh <= c1 / w;
    endfunction

    function automatic int stage_of(int h);
        if (h > CRK) return 1;
        if (h > CRM) return 2;
        if (h > 0)   return 3;
        return 0;
    endfunction

    function automatic logic [4:0] pix(int w, int h, int v);
        int dh, dv, st;
        bit body, blink, white, black, crack;
        dh = h - m_ph;
        dv = v - m_pv;
        if (!m_alive || dh < 0 || dv < 0) return 5'b0;
        body = 0;
        for (int k = 0; k < 39; k++)
            if (inr(dh, dv, 3 * k, 3 * k + 5, L_TAB[k], 75 - L_TAB[k], w)) body = 1;
        blink = (m_frames % BP) >= (BP - BL);
        white = !blink && (inr(dh, dv, 44, 70, 30, 47, w) || inr(dh, dv, 47, 65, 55, 69, w));
        black = (!blink && (inr(dh, dv, 49, 65, 35, 45, w) || inr(dh, dv, 51, 63, 59, 67, w))) ||
                inr(dh, dv, 74, 79, 39, 44, w) || inr(dh, dv, 76, 81, 42, 59, w) ||
                inr(dh, dv, 74, 79, 57, 62, w);
        st = stage_of(m_health);
        crack = (st >= 2 && inr(dh, dv, 10, 40, 50, 53, w)) || (st == 3 && inr(dh, dv, 80, 112, 20, 23, w));
        return {body, white, black, crack, body && (m_flash > 0)};
    endfunction

    task automatic step(bit rst, bit pl, int ph, int pv, bit bt, int h, int v);
        logic [4:0] f2, f1;
        bit org, tick, was_alive;
        exp_t e;
        @(negedge clk);
        reset = rst; plant = pl; plant_h = 10'(ph); plant_v = 10'(pv); bite = bt;
        hCount = 10'(h); vCount = 10'(v);
        f2 = rst ? 5'b0 : pix(2, h, v);
        f1 = rst ? 5'b0 : pix(1, h, v);
        org = (h == 0 && v == 0);
        if (rst) begin
            m_alive = 0; m_dead = 0; m_prev_org = 0;
            m_health = 0; m_ph = 0; m_pv = 0; m_frames = 0; m_flash = 0;
        end else begin
            tick = org && !m_prev_org;
            m_prev_org = org;
            m_dead = 0;
            if (pl) begin
                m_alive = 1; m_health = MAXH; m_ph = ph; m_pv = pv; m_frames = 0; m_flash = 0;
            end else begin
                was_alive = m_alive;
                if (bt && m_alive) begin
                    m_health = m_health - 1;
                    m_flash = FF;
                    m_dead = (m_health == 0);
                    m_alive = (m_health != 0);
                end else if (tick && m_flash > 0) begin
                    m_flash = m_flash - 1;
                end
                if (tick && was_alive) m_frames = m_frames + 1;
            end
        end
        e.e2 = {m_alive, 8'(m_health), 2'(stage_of(m_health)), m_dead, f2};
        e.e1 = {m_alive, 8'(m_health), 2'(stage_of(m_health)), m_dead, f1};
        q.push_back(e);
    endtask

    task automatic px(int h, int v);
        step(0, 0, 0, 0, 0, h, v);
    endtask

    task automatic frame();
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_plant(int ph, int pv);
        step(0, 1, ph, pv, 0, 5, 5);
    endtask

    task automatic do_bite(int h, int v);
        step(0, 0, 0, 0, 1, h, v);
    endtask

    // Monitor: one scoreboard entry retires per clock once outputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors += 2;
                if (act2 !== e.e2) begin
                    miscompares++;
                    $display("FAIL ws2 {alive,health,stage,dead,nut,white,black,crack,flash} got %b exp %b at %0t",
                             act2, e.e2, $time);
                end
                if (act1 !== e.e1) begin
                    miscompares++;
                    $display("FAIL ws1 {alive,health,stage,dead,nut,white,black,crack,flash} got %b exp %b at %0t",
                             act1, e.e1, $time);
                end
            end
        end
    end

    initial begin
        int h, v;
        step(1, 0, 0, 0, 0, 3, 3);
        step(1, 0, 0, 0, 0, 3, 3);

        do_plant(100, 200);
        px(100, 224); px(99, 224); px(117, 226); px(121, 239);

        // Eat through the nut: stage changes at bites 4 and 8, death pulse at 12.
        for (int i = 0; i < 12; i++) begin
            do_bite(110, 230);
            px(100, 224);
        end
        px(100, 224);
        do_bite(110, 230);
        px(110, 230);

        // Blink window: frames 114..119 close the eyes, frame 120 reopens them.
        do_plant(100, 200);
        for (int f = 0; f < 122; f++) begin
            px(117, 226); px(121, 239); px(130, 260);
            frame();
        end

        // Flash: bite, tick frames, re-bite on frame 2.
        do_bite(120, 230);
        for (int f = 0; f < 7; f++) begin
            px(120, 230);
            if (f == 2) do_bite(120, 232);
            frame();
        end
        px(120, 230);

        // Health down to 5, then plant and bite together.
        while (m_health > 5) do_bite(120, 230);
        step(0, 1, 100, 200, 1, 120, 230);
        px(120, 230); px(125, 210);

        // Bounding-box sweeps from one origin for both scales.
        do_plant(300, 300);
        for (int d = -2; d < 78; d++) px(300 + d, 330);
        for (int d = -2; d < 122; d++) px(320, 300 + d);

        // Reset in the middle of a frame while drawing the body.
        do_bite(320, 330);
        step(1, 0, 0, 0, 0, 320, 330);
        px(320, 330); px(320, 331);

        // Placement at the right/bottom raster edge.
        do_plant(1000, 1000);
        for (int d = 0; d < 24; d++) px(1000 + d, 1000 + d);

        for (int i = 0; i < 3000; i++) begin
            bit rst, pl, bt;
            int ph, pv;
            rst = ($urandom_range(0, 399) == 0);
            pl  = ($urandom_range(0, 99) < (m_alive ? 2 : 6));
            bt  = ($urandom_range(0, 99) < 6);
            ph  = ($urandom_range(0, 7) == 0) ? $urandom_range(940, 1023) : $urandom_range(0, 900);
            pv  = $urandom_range(0, 900);
            if ($urandom_range(0, 7) == 0) begin
                h = 0; v = 0;
            end else begin
                h = m_ph + $urandom_range(0, 82) - 3;
                v = m_pv + $urandom_range(0, 126) - 3;
                if (h < 0) h = 0;
                if (h > 1023) h = 1023;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
            end
            step(rst, pl, ph, pv, bt, h, v);
        end

        step(0, 0, 0, 0, 0, 7, 7);
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain entries left %0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
